extmem_ctrl: RTL

- Bus master sitting directly upstream of the external memory model. Arbitrates between the instruction-fetch port and the load/store data port.
- Converts byte addresses and access sizes into word address, byte enables and lane-aligned write data. Drives the shared tristate data bus and waits for done.
- Returns read data: zero/sign-extended for the data port, raw words for fetch.
- Enforces a timeout so a stalled memory cannot hang the pipeline.

---
 rtl/extmem_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/extmem_ctrl.sv
// extmem_ctrl: bus master for the external memory, arbitrating fetch and load/store ports.
// Rev 1.0 - initial release.
`default_nettype none

module extmem_ctrl #(
  parameter int AW      = 11,
  parameter int TIMEOUT = 15
) (
  input  logic          ph1,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic          d_signed,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic [AW-1:0] adr,
  inout  wire  [31:0]   data,
  output logic [3:0]    byteen,
  output logic          rwb,
  output logic          en,
  input  logic          done
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            is_d_q, is_d_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [1:0]      lane_q, lane_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            en_q, en_d;
  logic            rwb_q, rwb_d;
  logic [3:0]      byteen_q, byteen_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;

  logic            bad_d, bad_if;
  logic [3:0]      be_req;
  logic [31:0]     wrep;
  logic [31:0]     lane_shift, load_ext;
  logic [7:0]      cnt_inc;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^{d_addr[31:AW+2], if_addr[31:AW+2]};

  // The bus is only ever driven by us while a store sits in BUS.
  assign data = rwb_q ? 32'bz : wdata_q;

  // Data-port request decode: lane enables, lane-replicated write data, legality.
  always_comb begin
    bad_d  = 1'b0;
    be_req = 4'b1111;
    wrep   = d_wdata;
    case (d_size)
      2'b00: begin
        be_req = 4'b0001 << d_addr[1:0];
        wrep   = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        be_req = 4'b0011 << d_addr[1:0];
        wrep   = {2{d_wdata[15:0]}};
        bad_d  = d_addr[0];
      end
      2'b10:   bad_d = (d_addr[1:0] != 2'b00);
      default: bad_d = 1'b1;
    endcase
    bad_if = (if_addr[1:0] != 2'b00);
  end

  always_comb begin
    lane_shift = data >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{sgn_q & lane_shift[7]}}, lane_shift[7:0]};
      2'b01:   load_ext = {{16{sgn_q & lane_shift[15]}}, lane_shift[15:0]};
      default: load_ext = data;
    endcase
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    is_d_d     = is_d_q;
    we_d       = we_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    lane_d     = lane_q;
    adr_d      = adr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (d_req) begin
          is_d_d  = 1'b1;
          we_d    = d_we;
          size_d  = d_size;
          sgn_d   = d_signed;
          lane_d  = d_addr[1:0];
          err_d   = bad_d;
          state_d = bad_d ? S_RESP : S_BUS;
          if (!bad_d) begin
            adr_d   = d_addr[AW+1:2];
            be_d    = be_req;
            wdata_d = wrep;
          end
        end else if (if_req) begin
          is_d_d  = 1'b0;
          we_d    = 1'b0;
          size_d  = 2'b10;
          sgn_d   = 1'b0;
          lane_d  = if_addr[1:0];
          err_d   = bad_if;
          state_d = bad_if ? S_RESP : S_BUS;
          if (!bad_if) begin
            adr_d = if_addr[AW+1:2];
            be_d  = 4'b1111;
          end
        end
      end
      S_BUS: begin
        cnt_d = cnt_inc;
        if (done) begin
          err_d   = 1'b0;
          state_d = S_RESP;
          if (!we_q) begin
            if (is_d_q) d_rdata_d = load_ext;
            else        if_rdata_d = data;
          end
        end else if (cnt_inc == TO_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus strobes are registered from the next state so rwb cannot glitch low.
    en_d     = (state_d == S_BUS);
    rwb_d    = !((state_d == S_BUS) && we_d);
    byteen_d = (state_d == S_BUS) ? be_d : 4'b0000;
    d_ack_d  = (state_d == S_RESP) && is_d_d;
    if_ack_d = (state_d == S_RESP) && !is_d_d;
  end

  always_ff @(posedge ph1) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      is_d_q     <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      lane_q     <= 2'b00;
      adr_q      <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      cnt_q      <= 8'd0;
      en_q       <= 1'b0;
      rwb_q      <= 1'b1;
      byteen_q   <= 4'b0000;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      is_d_q     <= is_d_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      lane_q     <= lane_d;
      adr_q      <= adr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      rwb_q      <= rwb_d;
      byteen_q   <= byteen_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign adr      = adr_q;
  assign byteen   = byteen_q;
  assign rwb      = rwb_q;
  assign en       = en_q;
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign if_err   = if_ack_q & err_q;
  assign d_err    = d_ack_q & err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

`default_nettype wire
